// File: rtl/y86_pkg.sv
// Shared types and default sizes for the Y86 bus memory and its loader.
package y86_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_MEM_BYTES = 1024;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/y86_mem_loader.sv
// Boot loader FSM: streams bytes into memory while holding the CPU in reset,
// then releases the CPU and stays in RUN until rst_n.
module y86_mem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_valid,
  input  logic                         ld_last,
  output logic                         ld_ready,
  output logic                         cpu_rst,
  output logic                         ld_we,
  output logic [$clog2(MEM_BYTES)-1:0] load_ptr,
  output state_e                       state
);

  localparam int AW = $clog2(MEM_BYTES);

  // ld_ready is high only in LOAD, so an accepted byte implies LOAD.
  always_comb ld_we = ld_valid && ld_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_ptr <= '0;
      ld_ready <= 1'b1;
      cpu_rst  <= 1'b1;
    end else if (state == LOAD && ld_we) begin
      load_ptr <= load_ptr + AW'(1);
      if (ld_last || load_ptr == {AW{1'b1}}) begin
        state    <= RUN;
        ld_ready <= 1'b0;
        cpu_rst  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/y86_bus_mem.sv
// Y86 byte memory with loader port and 32-bit little-endian CPU bus.
// Optional feature: define Y86_MEM_BOUNDS_CHECK_EN for out-of-range detection.
module y86_bus_mem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      bus_A,
  input  logic             bus_RE,
  input  logic             bus_WE,
  input  logic [31:0]      bus_out,
  output logic [31:0]      bus_in,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`ifdef Y86_MEM_BOUNDS_CHECK_EN
  ,
  output logic             mem_err
`endif
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] a;
  logic [AW-1:0] load_ptr;
  logic          ld_we;
  state_e        state;
  logic          rd_acc;
  logic          wr_acc;
  logic          in_range;

  y86_mem_loader #(.MEM_BYTES(MEM_BYTES)) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .ld_we    (ld_we),
    .load_ptr (load_ptr),
    .state    (state)
  );

  assign a      = bus_A[AW-1:0];
  assign rd_acc = (state == RUN) && bus_RE;
  assign wr_acc = (state == RUN) && bus_WE;

`ifdef Y86_MEM_BOUNDS_CHECK_EN
  assign in_range = (bus_A <= 32'(MEM_BYTES - 4));
`else
  // Upper address bits are deliberately ignored; byte indices wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus_A[31:AW];
  assign in_range       = 1'b1;
`endif

  always_comb begin
    bus_in = '0;
    if (rd_acc && in_range) begin
      for (int i = 0; i < 4; i++) bus_in[8*i +: 8] = mem[a + AW'(i)];
    end
  end

  // NOTE: the byte array has no reset; clearing it would turn a RAM into
  // flops and contents are defined by the loader anyway.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[load_ptr] <= ld_data;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < 4; i++) mem[a + AW'(i)] <= bus_out[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_acc && rd_count != '1) rd_count <= rd_count + CNT_W'(1);
      if (wr_acc && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
    end
  end

`ifdef Y86_MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              mem_err <= 1'b0;
    else if ((rd_acc || wr_acc) && !in_range) mem_err <= 1'b1;
  end
`endif

endmodule

// File: doc/y86_bus_mem.md
Y86_BUS_MEM -- requirements
Module: y86_bus_mem

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, giving memory size in bytes (power of two, at least 8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the access counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 bus_A  input  32  CPU byte address.
REQ-006 bus_RE  input  1  CPU read strobe.
REQ-007 bus_WE  input  1  CPU write strobe.
REQ-008 bus_out  input  32  CPU write data.
REQ-009 bus_in  output  32  read data to the CPU.
REQ-010 ld_valid  input  1  loader byte valid.
REQ-011 ld_data  input  8  loader byte.
REQ-012 ld_last  input  1  marks the final loader byte.
REQ-013 ld_ready  output  1  loader may transfer.
REQ-014 cpu_rst  output  1  active-high reset driven to the CPU.
REQ-015 rd_count, wr_count  output  CNT_W each  accepted CPU read and write counts.
REQ-016 mem_err  output  1  sticky out-of-range flag; exists only with Y86_MEM_BOUNDS_CHECK_EN.

Function
REQ-017 The FSM SHALL have two states: LOAD and RUN.
REQ-018 In LOAD, ld_ready=1 and cpu_rst=1; a byte transfers on a cycle with ld_valid and ld_ready both high.
REQ-019 Each transferred byte SHALL be written to mem[load_ptr], after which load_ptr increments by 1.
REQ-020 LOAD->RUN occurs on the edge that accepts a byte with ld_last=1, or on the edge that accepts byte MEM_BYTES-1, whichever is first.
REQ-021 In RUN, ld_ready=0 and cpu_rst=0; cpu_rst falls on the same edge that enters RUN, so the CPU's first fetch is on the next cycle.
REQ-022 RUN SHALL persist until rst_n is asserted; ld_valid is ignored in RUN.
REQ-023 Reads are combinational, zero wait: when bus_RE=1 in RUN, bus_in={mem[A+3],mem[A+2],mem[A+1],mem[A]} (little-endian, unaligned allowed); otherwise bus_in=0.
REQ-024 Writes: on an edge with bus_WE=1 in RUN, bytes 0..3 of bus_out SHALL be written to mem[A..A+3], with the new data visible to reads from the next cycle.
REQ-025 Bus strobes in LOAD SHALL be ignored: no write, bus_in=0, counters unchanged.
REQ-026 If bus_RE and bus_WE are both high, the read returns the pre-write data and both counters increment.
REQ-027 rd_count and wr_count increment once per cycle of accepted strobe and saturate at all-ones (no wrap).
REQ-028 Byte index arithmetic SHALL be modulo MEM_BYTES; bus_A upper bits beyond log2(MEM_BYTES) are ignored unless bounds checking is compiled in.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously enter LOAD, with load_ptr=0, rd_count=0, wr_count=0, mem_err=0, cpu_rst=1, ld_ready=1, and bus_in=0.
REQ-030 Memory contents are not reset.
REQ-031 Reset asserted mid-load SHALL restart loading at address 0.

Configuration
REQ-032 With Y86_MEM_BOUNDS_CHECK_EN defined, an accepted access with bus_A > MEM_BYTES-4 SHALL read as 0, drop the write, still count, and set mem_err until reset.
REQ-033 Without Y86_MEM_BOUNDS_CHECK_EN, the mem_err port is absent and wrap per REQ-028 applies.

Structure
REQ-034 Shared package y86_pkg SHALL hold the state enum (LOAD, RUN) and the default MEM_BYTES and CNT_W constants.
REQ-035 The loader FSM and load_ptr SHALL be a sub-module y86_mem_loader, with the byte array and bus port in the top.

Verification
REQ-036 Reset, then load bytes 8B,45,04 with ld_last on the third -> ld_ready falls and cpu_rst falls on that edge; bus_RE at A=0 gives bus_in=0x??04458B, with byte 3 as loaded or 0 after a fresh image.
REQ-037 RUN, bus_WE at A=0x10 with data 0xDEADBEEF, then bus_RE at A=0x11 -> bus_in[23:0]=0xDEADBE, and wr_count=1, rd_count=1.
REQ-038 Load MEM_BYTES bytes without ld_last -> RUN entered after byte 1023; a 1025th ld_valid is not accepted.
REQ-039 Drive both strobes at A=0x20, previous value 0x11223344, new data 0x55 -> bus_in=0x11223344 that cycle and 0x00000055 next cycle.
REQ-040 With the macro, bus_RE at A=0x3FE (MEM_BYTES=1024) -> bus_in=0 and mem_err=1; without the macro, bus_in={mem[1],mem[0],mem[0x3FF],mem[0x3FE]}.
REQ-041 Assert rst_n low mid-load after 5 bytes -> ld_ready=1 and cpu_rst=1 immediately; the next byte goes to address 0.
